// File: rtl/btn_debounce_core.sv
// btn_debounce_core
//
// Debounces a bank of W mechanical push-button inputs and exposes them on the
// FPro MMIO slot bus. Each bit has its own two-flop synchronizer, its own
// debounce state machine with an N-bit stability counter, and sticky
// rising/falling edge flags that software clears by writing ones.
//
// Register map (rd_data is combinational on addr, bits above W read 0):
//   0 : synchronized raw inputs              (read-only)
//   1 : debounced levels                     (read-only)
//   2 : sticky rising-edge flags             (write 1 to clear)
//   3 : sticky falling-edge flags            (write 1 to clear)
//   4..31 : read 0, writes ignored
//
// Ports:
//   clk      system clock
//   reset    synchronous active-high reset
//   cs       slot select
//   read     read strobe (no side effects, not needed by this core)
//   write    write strobe, qualified by cs
//   addr     register index
//   wr_data  write data (clear masks for addr 2 and 3)
//   rd_data  read data
//   din      asynchronous button inputs
module btn_debounce_core #(
  parameter int W = 5,
  parameter int N = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  input  logic [W-1:0] din
);

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } state_t;

  localparam logic [N-1:0] CNT_MAX = '1;

  logic [W-1:0] sync1_q, sync2_q;
  state_t       state_q [W];
  state_t       state_d [W];
  logic [N-1:0] cnt_q [W];
  logic [N-1:0] cnt_d [W];
  logic [W-1:0] dbLevel;
  logic [W-1:0] rise, fall;
  logic [W-1:0] riseFlag_q, riseFlag_d;
  logic [W-1:0] fallFlag_q, fallFlag_d;
  logic [W-1:0] clrRise, clrFall;
  logic         unusedBits;

  // read has no side effects and wr_data bits above W never matter.
  assign unusedBits = ^{read, wr_data};

  // Two-flop synchronizer; sync2_q is the only copy of din the FSMs see.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
    end
  end

  // Per-bit FSM state and stability counter.
  always_ff @(posedge clk) begin
    for (int i = 0; i < W; i++) begin
      if (reset) begin
        state_q[i] <= ZERO;
        cnt_q[i]   <= '0;
      end else begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Next-state logic. The counter is compared before it increments, so a
  // change must be seen for 2^N+1 consecutive samples before it commits,
  // and the counter never wraps. rise/fall are combinational so the flags
  // set on the very edge the debounced level changes.
  always_comb begin
    for (int i = 0; i < W; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      rise[i]    = 1'b0;
      fall[i]    = 1'b0;
      case (state_q[i])
        ZERO: begin
          if (sync2_q[i]) begin
            state_d[i] = WAIT1;
            cnt_d[i]   = '0;
          end
        end
        WAIT1: begin
          if (!sync2_q[i]) begin
            state_d[i] = ZERO;
          end else if (cnt_q[i] == CNT_MAX) begin
            state_d[i] = ONE;
            rise[i]    = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        ONE: begin
          if (!sync2_q[i]) begin
            state_d[i] = WAIT0;
            cnt_d[i]   = '0;
          end
        end
        WAIT0: begin
          if (sync2_q[i]) begin
            state_d[i] = ONE;
          end else if (cnt_q[i] == CNT_MAX) begin
            state_d[i] = ZERO;
            fall[i]    = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        default: begin
          state_d[i] = ZERO;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // The debounced level is high in ONE and while waiting to confirm a release.
  always_comb begin
    for (int i = 0; i < W; i++) begin
      dbLevel[i] = (state_q[i] == ONE) || (state_q[i] == WAIT0);
    end
  end

  // Clear masks only exist during a selected write to the flag registers.
  always_comb begin
    clrRise = '0;
    clrFall = '0;
    if (cs && write) begin
      if (addr == 5'd2) clrRise = wr_data[W-1:0];
      if (addr == 5'd3) clrFall = wr_data[W-1:0];
    end
  end

  // A new edge wins over a simultaneous clear so no event is ever lost.
  always_comb begin
    riseFlag_d = rise | (riseFlag_q & ~clrRise);
    fallFlag_d = fall | (fallFlag_q & ~clrFall);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      riseFlag_q <= '0;
      fallFlag_q <= '0;
    end else begin
      riseFlag_q <= riseFlag_d;
      fallFlag_q <= fallFlag_d;
    end
  end

  // Zero-latency read mux, independent of cs and read.
  always_comb begin
    rd_data = '0;
    case (addr)
      5'd0:    rd_data[W-1:0] = sync2_q;
      5'd1:    rd_data[W-1:0] = dbLevel;
      5'd2:    rd_data[W-1:0] = riseFlag_q;
      5'd3:    rd_data[W-1:0] = fallFlag_q;
      default: rd_data = '0;
    endcase
  end

endmodule
